// File: rtl/camera_pkg.sv
// Shared camera-control definitions: state encodings and default timer parameters.
package camera_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXPOSE  = 2'd1,
    READOUT = 2'd2
  } cam_state_e;

  localparam int DEF_CNT_W     = 5;
  localparam int DEF_EXP_MIN   = 2;
  localparam int DEF_EXP_MAX   = 30;
  localparam int DEF_PRESCALE  = 1;
  localparam int DEF_RD_CYCLES = 4;
  localparam int DEF_FRM_W     = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into one-cycle ticks every PRESCALE enabled clocks.
// With PRESCALE=1 the counter stays at 0 and tick follows en directly.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/exposure_timer.sv
// Exposure/readout sequencer: clamped exposure in prescaled ticks, fixed readout,
// continuous re-trigger, abort and a wrapping frame counter.
//
//   state   | meaning
//   IDLE    | waiting for Start
//   EXPOSE  | counting N prescaler ticks of exposure
//   READOUT | counting RD_CYCLES clocks of sensor readout
module exposure_timer
  import camera_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int EXP_MIN   = DEF_EXP_MIN,
  parameter int EXP_MAX   = DEF_EXP_MAX,
  parameter int PRESCALE  = DEF_PRESCALE,
  parameter int RD_CYCLES = DEF_RD_CYCLES,
  parameter int FRM_W     = DEF_FRM_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Cont,
  input  logic             Abort,
  input  logic [CNT_W-1:0] Exp_Time,
  output logic             Expose,
  output logic             Readout,
  output logic             Busy,
  output logic             Ovf5,
  output logic             Ovf4,
  output logic             Aborted,
  output logic [FRM_W-1:0] Frame_Cnt
);

  localparam int               RD_W    = (RD_CYCLES > 1) ? $clog2(RD_CYCLES) : 1;
  localparam logic [RD_W-1:0]  RD_LAST = RD_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] N_MIN   = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0] N_MAX   = CNT_W'(EXP_MAX);

  cam_state_e       state, state_nxt;
  logic [CNT_W-1:0] n_lat, n_clamp, exp_cnt;
  logic [RD_W-1:0]  rd_cnt;
  logic             exp_en, tick, exp_done, rd_done;
  logic             go_expose, latch_n, ovf5_nxt, ovf4_nxt, aborted_nxt;

  assign n_clamp  = (Exp_Time < N_MIN) ? N_MIN : ((Exp_Time > N_MAX) ? N_MAX : Exp_Time);
  assign exp_en   = (state == EXPOSE);
  assign exp_done = tick && (exp_cnt == n_lat - CNT_W'(1));
  assign rd_done  = (rd_cnt == RD_LAST);

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .Clk     (Clk),
    .Reset   (Reset),
    .restart (go_expose),
    .en      (exp_en),
    .tick    (tick)
  );

  always_comb begin
    state_nxt   = state;
    go_expose   = 1'b0;
    latch_n     = 1'b0;
    ovf5_nxt    = 1'b0;
    ovf4_nxt    = 1'b0;
    aborted_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (Start && !Abort) begin
          state_nxt = EXPOSE;
          go_expose = 1'b1;
          latch_n   = 1'b1;
        end
      end
      EXPOSE: begin
        if (Abort) begin
          state_nxt   = IDLE;
          aborted_nxt = 1'b1;
        end else if (exp_done) begin
          state_nxt = READOUT;
          ovf5_nxt  = 1'b1;
        end
      end
      READOUT: begin
        if (Abort) begin
          state_nxt   = IDLE;
          aborted_nxt = 1'b1;
        end else if (rd_done) begin
          ovf4_nxt = 1'b1;
          // continuous mode reuses the latched exposure, no new Start needed
          if (Cont) begin
            state_nxt = EXPOSE;
            go_expose = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      n_lat     <= '0;
      exp_cnt   <= '0;
      rd_cnt    <= '0;
      Expose    <= 1'b0;
      Readout   <= 1'b0;
      Busy      <= 1'b0;
      Ovf5      <= 1'b0;
      Ovf4      <= 1'b0;
      Aborted   <= 1'b0;
      Frame_Cnt <= '0;
    end else begin
      state <= state_nxt;
      if (latch_n) n_lat <= n_clamp;
      if (go_expose) exp_cnt <= '0;
      else if (tick) exp_cnt <= exp_cnt + CNT_W'(1);
      rd_cnt    <= (state == READOUT) ? rd_cnt + RD_W'(1) : '0;
      Expose    <= (state_nxt == EXPOSE);
      Readout   <= (state_nxt == READOUT);
      Busy      <= (state_nxt != IDLE);
      Ovf5      <= ovf5_nxt;
      Ovf4      <= ovf4_nxt;
      Aborted   <= aborted_nxt;
      if (ovf4_nxt) Frame_Cnt <= Frame_Cnt + FRM_W'(1);
    end
  end

endmodule

// File: tb/tb_exposure_timer.sv
// Directed bench for exposure_timer: default instance plus a PRESCALE=4, FRM_W=2 instance.
module tb_exposure_timer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_start, a_cont, a_abort;
  logic [4:0] a_exp;
  logic       a_expose, a_readout, a_busy, a_ovf5, a_ovf4, a_aborted;
  logic [7:0] a_frame;

  logic       b_start, b_cont, b_abort;
  logic [4:0] b_exp;
  logic       b_expose, b_readout, b_busy, b_ovf5, b_ovf4, b_aborted;
  logic [1:0] b_frame;

  int total = 0;
  int bad   = 0;
  int e, r;
  logic o5;

  exposure_timer u_a (
    .Clk(clk), .Reset(rst), .Start(a_start), .Cont(a_cont), .Abort(a_abort),
    .Exp_Time(a_exp), .Expose(a_expose), .Readout(a_readout), .Busy(a_busy),
    .Ovf5(a_ovf5), .Ovf4(a_ovf4), .Aborted(a_aborted), .Frame_Cnt(a_frame)
  );

  exposure_timer #(.PRESCALE(4), .FRM_W(2)) u_b (
    .Clk(clk), .Reset(rst), .Start(b_start), .Cont(b_cont), .Abort(b_abort),
    .Exp_Time(b_exp), .Expose(b_expose), .Readout(b_readout), .Busy(b_busy),
    .Ovf5(b_ovf5), .Ovf4(b_ovf4), .Aborted(b_aborted), .Frame_Cnt(b_frame)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // counts Expose-high cycles, then Readout-high cycles; o5 = Ovf5 seen with first Readout cycle
  task automatic meas_a(output int ec, output int rc, output logic p5);
    ec = 0;
    rc = 0;
    while (a_expose && ec < 200) begin ec++; step(); end
    p5 = a_ovf5 & a_readout;
    while (a_readout && rc < 200) begin rc++; step(); end
  endtask

  task automatic meas_b(output int ec, output int rc, output logic p5);
    ec = 0;
    rc = 0;
    while (b_expose && ec < 200) begin ec++; step(); end
    p5 = b_ovf5 & b_readout;
    while (b_readout && rc < 200) begin rc++; step(); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_start = 0; a_cont = 0; a_abort = 0; a_exp = '0;
    b_start = 0; b_cont = 0; b_abort = 0; b_exp = '0;
    #12;
    chk("rst_a_outs", 32'({a_expose, a_readout, a_busy, a_ovf5, a_ovf4, a_aborted, a_frame}), 0);
    chk("rst_b_outs", 32'({b_expose, b_readout, b_busy, b_ovf5, b_ovf4, b_aborted, b_frame}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // basic exposure, N=8
    a_exp = 5'd8; a_start = 1; step(); a_start = 0;
    chk("a8_rise", 32'({a_expose, a_busy, a_readout}), 32'b110);
    meas_a(e, r, o5);
    chk("a8_expose_len", 32'(e), 8);
    chk("a8_ovf5", 32'(o5), 1);
    chk("a8_readout_len", 32'(r), 4);
    chk("a8_ovf4", 32'(a_ovf4), 1);
    chk("a8_frame", 32'(a_frame), 1);
    chk("a8_busy_low", 32'(a_busy), 0);
    step();
    chk("a8_ovf4_pulse", 32'({a_ovf4, a_ovf5}), 0);

    // clamping
    a_exp = 5'd0; a_start = 1; step(); a_start = 0;
    meas_a(e, r, o5);
    chk("clamp_min_len", 32'(e), 2);
    chk("clamp_min_frame", 32'(a_frame), 2);
    a_exp = 5'd31; a_start = 1; step(); a_start = 0;
    meas_a(e, r, o5);
    chk("clamp_max_len", 32'(e), 30);
    chk("clamp_max_rd", 32'(r), 4);
    chk("clamp_max_frame", 32'(a_frame), 3);
    step();

    // continuous mode, N=5, period 9
    a_cont = 1; a_exp = 5'd5; a_start = 1; step(); a_start = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) a_cont = 0;
      meas_a(e, r, o5);
      chk("cont_expose_len", 32'(e), 5);
      chk("cont_readout_len", 32'(r), 4);
      chk("cont_ovf4", 32'(a_ovf4), 1);
      chk("cont_frame", 32'(a_frame), 32'(4 + i));
      if (i < 2) chk("cont_reexpose", 32'(a_expose), 1);
      else       chk("cont_end_busy", 32'(a_busy), 0);
    end
    step();

    // abort mid-exposure
    a_exp = 5'd10; a_start = 1; step(); a_start = 0;
    steps(3);
    a_abort = 1; step(); a_abort = 0;
    chk("abort_exp_outs", 32'({a_busy, a_expose, a_readout, a_aborted}), 32'b0001);
    chk("abort_exp_frame", 32'(a_frame), 6);
    step();
    chk("abort_exp_pulse", 32'(a_aborted), 0);
    steps(12);
    chk("abort_exp_quiet", 32'({a_busy, a_ovf4, a_ovf5}), 0);

    // abort on the last readout cycle
    a_exp = 5'd2; a_start = 1; step(); a_start = 0;
    steps(5);
    chk("abort_rd_inrd", 32'(a_readout), 1);
    a_abort = 1; step(); a_abort = 0;
    chk("abort_rd_outs", 32'({a_busy, a_readout, a_aborted, a_ovf4}), 32'b0010);
    chk("abort_rd_frame", 32'(a_frame), 6);
    step();
    chk("abort_rd_after", 32'({a_ovf4, a_aborted, a_frame}), 32'(6));

    // abort in IDLE, and abort beating start
    a_start = 1; a_abort = 1; step();
    chk("idle_abort", 32'({a_busy, a_aborted}), 0);
    a_start = 0; a_abort = 0; step();

    // level-held start re-triggers one cycle after IDLE
    a_exp = 5'd2; a_start = 1; step();
    meas_a(e, r, o5);
    chk("held_len", 32'(e), 2);
    chk("held_done", 32'({a_ovf4, a_busy}), 32'b10);
    chk("held_frame", 32'(a_frame), 7);
    step();
    chk("held_retrig", 32'({a_busy, a_expose}), 32'b11);
    a_start = 0;
    meas_a(e, r, o5);
    chk("held_len2", 32'(e), 2);
    chk("held_frame2", 32'(a_frame), 8);
    step();

    // prescale 4, N=3; mid-sequence Start and Exp_Time change ignored
    b_exp = 5'd3; b_start = 1; step(); b_start = 0;
    steps(2);
    b_start = 1; b_exp = 5'd30; step(); b_start = 0;
    meas_b(e, r, o5);
    chk("b_expose_len", 32'(e + 3), 12);
    chk("b_ovf5", 32'(o5), 1);
    chk("b_readout_len", 32'(r), 4);
    chk("b_done", 32'({b_ovf4, b_busy, b_frame}), 32'b1001);
    steps(4);
    chk("b_no_retrig", 32'(b_busy), 0);

    // frame counter wrap with 2-bit counter
    b_exp = 5'd2; b_cont = 1; b_start = 1; step(); b_start = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) b_cont = 0;
      meas_b(e, r, o5);
      chk("wrap_expose_len", 32'(e), 8);
      chk("wrap_readout_len", 32'(r), 4);
      chk("wrap_ovf4", 32'(b_ovf4), 1);
      chk("wrap_frame", 32'(b_frame), 32'((i + 2) % 4));
    end
    chk("wrap_end_busy", 32'(b_busy), 0);
    step();

    // asynchronous reset mid-readout
    b_exp = 5'd2; b_start = 1; step(); b_start = 0;
    steps(9);
    chk("arst_inrd", 32'(b_readout), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_b_outs", 32'({b_expose, b_readout, b_busy, b_ovf5, b_ovf4, b_aborted, b_frame}), 0);
    chk("arst_a_outs", 32'({a_expose, a_readout, a_busy, a_ovf5, a_ovf4, a_aborted, a_frame}), 0);
    step();
    chk("arst_b_hold", 32'({b_expose, b_readout, b_busy, b_ovf5, b_ovf4, b_aborted, b_frame}), 0);
    rst = 1'b0;
    step();
    chk("arst_b_idle", 32'({b_busy, b_ovf4}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
